// File: rtl/modport_spi_slave.sv
// modport_spi_slave: SPI slave endpoint that turns an external SPI bus into a
// byte-wide controller interface in the i_Clk domain. SPI pins are brought into
// i_Clk through 2-flop synchronisers; SCLK edges are found on the synchronised
// copy, so i_Clk must run at least 8x faster than SCLK.
`timescale 1ns/1ps

module modport_spi_slave #(
  parameter int SPI_MODE = 0
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_TX_DV,
  output logic       o_TX_Ready,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  input  logic       i_SPI_Clk,
  input  logic       i_SPI_MOSI,
  output logic       o_SPI_MISO,
  input  logic       i_SPI_CS_n
);

  localparam logic [1:0] MODE_BITS = 2'(SPI_MODE);
  localparam logic       CPOL      = MODE_BITS[1];
  localparam logic       CPHA      = MODE_BITS[0];

  // Synchroniser stages plus one extra stage on SCLK and CS_n for edge detection
  logic spi_clk_meta_q, spi_clk_sync_q, spi_clk_prev_q;
  logic mosi_meta_q, mosi_sync_q;
  logic cs_n_meta_q, cs_n_sync_q, cs_n_prev_q;

  // Edge / framing decode
  logic cs_active_s;
  logic cs_fall_s;
  logic lead_edge_s;
  logic trail_edge_s;
  logic sample_edge_s;
  logic drive_edge_s;
  logic byte_done_s;
  logic boundary_s;

  // Receive path
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_dv_q, rx_dv_d;

  // Transmit path
  logic       tx_load_s;
  logic [7:0] bnd_byte_s;
  logic [7:0] tx_hold_q, tx_hold_d;
  logic       tx_full_q, tx_full_d;
  logic       tx_ready_q, tx_ready_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       miso_q, miso_d;

  // Bring the asynchronous SPI pins into i_Clk; idle levels avoid a false edge at reset release
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      spi_clk_meta_q <= CPOL;
      spi_clk_sync_q <= CPOL;
      spi_clk_prev_q <= CPOL;
      mosi_meta_q    <= 1'b0;
      mosi_sync_q    <= 1'b0;
      cs_n_meta_q    <= 1'b1;
      cs_n_sync_q    <= 1'b1;
      cs_n_prev_q    <= 1'b1;
    end else begin
      spi_clk_meta_q <= i_SPI_Clk;
      spi_clk_sync_q <= spi_clk_meta_q;
      spi_clk_prev_q <= spi_clk_sync_q;
      mosi_meta_q    <= i_SPI_MOSI;
      mosi_sync_q    <= mosi_meta_q;
      cs_n_meta_q    <= i_SPI_CS_n;
      cs_n_sync_q    <= cs_n_meta_q;
      cs_n_prev_q    <= cs_n_sync_q;
    end
  end

  // Decode leading/trailing SCLK edges and byte boundaries from the synchronised pins
  always_comb begin
    cs_active_s   = ~cs_n_sync_q;
    cs_fall_s     = cs_n_prev_q & ~cs_n_sync_q;
    lead_edge_s   = cs_active_s & (spi_clk_prev_q == CPOL) & (spi_clk_sync_q != CPOL);
    trail_edge_s  = cs_active_s & (spi_clk_prev_q != CPOL) & (spi_clk_sync_q == CPOL);
    sample_edge_s = CPHA ? trail_edge_s : lead_edge_s;
    drive_edge_s  = CPHA ? lead_edge_s : trail_edge_s;
    byte_done_s   = sample_edge_s & (bit_cnt_q == 3'd7);
    boundary_s    = cs_fall_s | byte_done_s;
  end

  // Shift MOSI in MSB first; publish the byte and pulse RX_DV on the 8th sample
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    rx_dv_d    = 1'b0;
    if (!cs_active_s) begin
      // Deselected (including mid-byte abort): drop any partial byte
      bit_cnt_d  = 3'd0;
      rx_shift_d = 7'd0;
    end else if (sample_edge_s) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        rx_byte_d  = {rx_shift_q, mosi_sync_q};
        rx_dv_d    = 1'b1;
        rx_shift_d = 7'd0;
      end else begin
        rx_shift_d = {rx_shift_q[5:0], mosi_sync_q};
      end
    end else begin
      bit_cnt_d  = bit_cnt_q;
      rx_shift_d = rx_shift_q;
    end
  end

  // Holding register: the boundary transfer empties it first, then a same-cycle load refills it
  always_comb begin
    tx_load_s  = i_TX_DV & tx_ready_q;
    bnd_byte_s = tx_full_q ? tx_hold_q : 8'h00;
    tx_hold_d  = tx_load_s ? i_TX_Byte : (boundary_s ? 8'h00 : tx_hold_q);
    tx_full_d  = tx_load_s | (tx_full_q & ~boundary_s);
    tx_ready_d = ~tx_full_d;
  end

  // MISO shifter: CPHA=0 presents bit 7 at the boundary and advances on trailing edges,
  // skipping the trailing edge that closes a byte; CPHA=1 presents each bit on a leading edge
  always_comb begin
    tx_shift_d = tx_shift_q;
    miso_d     = miso_q;
    if (!cs_active_s) begin
      tx_shift_d = 8'h00;
    end else if (boundary_s) begin
      tx_shift_d = bnd_byte_s;
      miso_d     = CPHA ? miso_q : bnd_byte_s[7];
    end else if (drive_edge_s && (CPHA || (bit_cnt_q != 3'd0))) begin
      miso_d     = CPHA ? tx_shift_q[7] : tx_shift_q[6];
      tx_shift_d = {tx_shift_q[6:0], 1'b0};
    end else begin
      tx_shift_d = tx_shift_q;
      miso_d     = miso_q;
    end
  end

  // State registers for the receive and transmit paths
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      bit_cnt_q  <= 3'd0;
      rx_shift_q <= 7'd0;
      rx_byte_q  <= 8'h00;
      rx_dv_q    <= 1'b0;
      tx_hold_q  <= 8'h00;
      tx_full_q  <= 1'b0;
      tx_ready_q <= 1'b0;
      tx_shift_q <= 8'h00;
      miso_q     <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      rx_dv_q    <= rx_dv_d;
      tx_hold_q  <= tx_hold_d;
      tx_full_q  <= tx_full_d;
      tx_ready_q <= tx_ready_d;
      tx_shift_q <= tx_shift_d;
      miso_q     <= miso_d;
    end
  end

  assign o_RX_DV    = rx_dv_q;
  assign o_RX_Byte  = rx_byte_q;
  assign o_TX_Ready = tx_ready_q;
  // Release the shared MISO line whenever deselected or held in reset
  assign o_SPI_MISO = (i_SPI_CS_n || !i_Rst_L) ? 1'bz : miso_q;

endmodule

// File: tb/tb_modport_spi_slave.sv
// tb_modport_spi_slave: one slave per SPI mode on private buses, driven by a
// behavioural SPI master; a transaction-level model predicts RX bytes and the
// byte each frame slot returns on MISO.
`timescale 1ns/1ps

module tb_modport_spi_slave;

  localparam int HALF = 8;  // i_Clk cycles per SCLK half period

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_byte;
  logic [3:0] tx_dv_v;
  logic [3:0] sclk_v;
  logic [3:0] mosi_v;
  logic [3:0] cs_v;
  wire  [3:0] ready_w;
  wire  [3:0] rx_dv_w;
  wire  [3:0] miso_w;
  wire  [7:0] rx_byte_w [4];

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: holding register per mode, received bytes tagged with mode
  logic [7:0] m_hold [4];
  logic       m_full [4];
  logic [9:0] rx_got [$];
  logic [3:0] dv_prev = 4'h0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    wire miso_g;
    pullup (miso_g);
    modport_spi_slave #(.SPI_MODE(g)) u_dut (
      .i_Clk      (clk),
      .i_Rst_L    (rst_n),
      .i_TX_Byte  (tx_byte),
      .i_TX_DV    (tx_dv_v[g]),
      .o_TX_Ready (ready_w[g]),
      .o_RX_DV    (rx_dv_w[g]),
      .o_RX_Byte  (rx_byte_w[g]),
      .i_SPI_Clk  (sclk_v[g]),
      .i_SPI_MOSI (mosi_v[g]),
      .o_SPI_MISO (miso_g),
      .i_SPI_CS_n (cs_v[g])
    );
    assign miso_w[g] = miso_g;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Byte boundary in the model: holding content (or 0x00) goes out next
  function automatic logic [7:0] m_boundary(input int m);
    logic [7:0] r;
    r = m_full[m] ? m_hold[m] : 8'h00;
    m_full[m] = 1'b0;
    return r;
  endfunction

  task automatic load(input int m, input logic [7:0] b);
    tx_byte    = b;
    tx_dv_v[m] = 1'b1;
    wait_cyc(1);
    tx_dv_v[m] = 1'b0;
    if (!m_full[m]) begin
      m_hold[m] = b;
      m_full[m] = 1'b1;
    end
  endtask

  // Master frame: n bytes (byte k = mo[8k+:8]); during byte k optionally load nxt[8k+:8];
  // abort_bits > 0 raises CS after that many bits of the first byte
  task automatic spi_frame(input int m, input int n, input logic [23:0] mo,
                           input logic [23:0] nxt, input logic [2:0] nxt_en, input int abort_bits);
    logic [1:0] md;
    logic       cpol;
    logic       cpha;
    logic [7:0] exp_tx;
    logic [7:0] got_tx;
    logic [7:0] b;
    logic [9:0] e;
    int         nb;
    int         exp_n;
    md   = 2'(m);
    cpol = md[1];
    cpha = md[0];
    nb   = (abort_bits > 0) ? abort_bits : 8;
    cs_v[m] = 1'b0;
    exp_tx  = m_boundary(m);
    wait_cyc(HALF);
    for (int k = 0; k < n; k++) begin
      b      = mo[8*k +: 8];
      got_tx = 8'h00;
      for (int j = 0; j < nb; j++) begin
        if (j == 4) begin
          chk($sformatf("ready_m%0d_b%0d", m, k), 32'(ready_w[m]), 32'(!m_full[m]));
          if (nxt_en[k]) load(m, nxt[8*k +: 8]);
        end
        if (!cpha) begin
          mosi_v[m] = b[7-j];
          wait_cyc(HALF);
          sclk_v[m] = ~cpol;
          got_tx[7-j] = miso_w[m];
          wait_cyc(HALF);
          sclk_v[m] = cpol;
        end else begin
          sclk_v[m] = ~cpol;
          mosi_v[m] = b[7-j];
          wait_cyc(HALF);
          sclk_v[m] = cpol;
          got_tx[7-j] = miso_w[m];
          wait_cyc(HALF);
        end
      end
      if (abort_bits == 0) begin
        chk($sformatf("miso_m%0d_b%0d", m, k), 32'(got_tx), 32'(exp_tx));
        exp_tx = m_boundary(m);
      end
    end
    wait_cyc(HALF);
    cs_v[m] = 1'b1;
    wait_cyc(4 * HALF);
    exp_n = (abort_bits > 0) ? 0 : n;
    chk($sformatf("rx_count_m%0d", m), rx_got.size(), exp_n);
    for (int k = 0; k < exp_n; k++) begin
      if (rx_got.size() > 0) begin
        e = rx_got.pop_front();
        chk($sformatf("rx_byte_m%0d_b%0d", m, k), 32'(e), 32'({md, mo[8*k +: 8]}));
      end
    end
    rx_got.delete();
  endtask

  // Collect RX_DV pulses away from the active edge; two consecutive highs are an error
  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (rx_dv_w[g]) begin
        rx_got.push_back({2'(g), rx_byte_w[g]});
        if (dv_prev[g]) chk("rx_dv_consecutive", 32'd1, 32'd0);
      end
    end
    dv_prev <= rx_dv_w;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    tx_byte = 8'h00;
    tx_dv_v = 4'h0;
    mosi_v  = 4'h0;
    cs_v    = 4'hF;
    sclk_v  = 4'b1100;
    for (int m = 0; m < 4; m++) begin
      m_hold[m] = 8'h00;
      m_full[m] = 1'b0;
    end
    wait_cyc(3);
    chk("rst_ready", 32'(ready_w), 32'h0);
    chk("rst_rx_dv", 32'(rx_dv_w), 32'h0);
    chk("rst_rx_byte", 32'(rx_byte_w[0]), 32'h0);
    rst_n = 1'b1;
    wait_cyc(1);
    chk("ready_after_rst", 32'(ready_w), 32'hF);

    // Mode 0 RX with nothing loaded: MISO returns 0x00
    spi_frame(0, 1, 24'h0000A5, 24'h0, 3'b000, 0);

    // Mode 0 TX
    load(0, 8'h3C);
    chk("ready_after_load", 32'(ready_w[0]), 32'h0);
    spi_frame(0, 1, 24'h000042, 24'h0, 3'b000, 0);

    // Load while not ready is ignored
    load(0, 8'h77);
    load(0, 8'hEE);
    chk("ready_after_ignored", 32'(ready_w[0]), 32'h0);
    spi_frame(0, 1, 24'h000019, 24'h0, 3'b000, 0);

    // Modes 1..3: back-to-back 0x00, 0xFF, 0x81 with preloads, then no preload
    for (int m = 1; m < 4; m++) begin
      load(m, 8'hC6);
      spi_frame(m, 3, 24'h81FF00, 24'h003DE7, 3'b011, 0);
      spi_frame(m, 2, 24'h005A3C, 24'h0, 3'b000, 0);
    end

    // Abort after 5 bits with a byte loaded mid-abort; it must survive to the next frame
    for (int m = 0; m < 4; m++) begin
      spi_frame(m, 1, 24'h0000FF, 24'h0000B4, 3'b001, 5);
      spi_frame(m, 1, 24'h00005A, 24'h0, 3'b000, 0);
    end

    // Randomised frames across all modes
    for (int r = 0; r < 12; r++) begin
      int          m;
      int          n;
      logic [23:0] mo;
      logic [23:0] nx;
      logic [2:0]  en;
      m  = $urandom_range(0, 3);
      n  = $urandom_range(1, 3);
      mo = 24'($urandom);
      nx = 24'($urandom);
      en = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) load(m, 8'($urandom));
      spi_frame(m, n, mo, nx, en, 0);
    end

    // Reset mid-transfer on mode 0
    load(0, 8'h66);
    cs_v[0] = 1'b0;
    wait_cyc(HALF);
    for (int j = 0; j < 3; j++) begin
      mosi_v[0] = 1'b1;
      wait_cyc(HALF);
      sclk_v[0] = 1'b1;
      wait_cyc(HALF);
      sclk_v[0] = 1'b0;
    end
    wait_cyc(HALF);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_rx_dv", 32'(rx_dv_w), 32'h0);
    chk("midrst_rx_byte", 32'(rx_byte_w[0]), 32'h0);
    chk("midrst_ready", 32'(ready_w), 32'h0);
    chk("midrst_miso_z", 32'(miso_w[0]), 32'h1);
    for (int m = 0; m < 4; m++) begin
      m_hold[m] = 8'h00;
      m_full[m] = 1'b0;
    end
    cs_v[0] = 1'b1;
    wait_cyc(4);
    rst_n = 1'b1;
    wait_cyc(1);
    chk("ready_after_midrst", 32'(ready_w), 32'hF);
    wait_cyc(4 * HALF);
    chk("midrst_no_partial", rx_got.size(), 0);
    spi_frame(0, 1, 24'h0000C3, 24'h0, 3'b000, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
